// File: rtl/rv_retire_checker.sv
// rv_retire_checker: watches the core's retirement outputs and compares them
// against a loadable table of (instruction count, output value) checkpoints,
// reporting pass, fail or timeout together with diagnostic captures.
module rv_retire_checker #(
  parameter int          NUM_TEST       = 23,
  parameter int          IDXW           = 5,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            LOAD_EN,
  input  logic [IDXW-1:0] LOAD_IDX,
  input  logic [31:0]     LOAD_NUM_INST,
  input  logic [31:0]     LOAD_ANS,
  input  logic [IDXW:0]   NUM_ENTRIES,
  input  logic            START,
  input  logic            CLR,
  input  logic [31:0]     NUM_INST,
  input  logic [31:0]     OUTPUT_PORT,
  input  logic            HALT,
  output logic [2:0]      STATE,
  output logic            DONE,
  output logic            PASSED,
  output logic [IDXW:0]   PASS_CNT,
  output logic [31:0]     CYCLE_CNT,
  output logic [IDXW-1:0] FAIL_IDX,
  output logic [31:0]     FAIL_ACT,
  output logic [31:0]     FAIL_EXP,
  output logic [1:0]      FAIL_CODE
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [IDXW:0] MAX_CNT = (IDXW+1)'(NUM_TEST);

  logic [31:0]     tab_num [NUM_TEST];
  logic [31:0]     tab_ans [NUM_TEST];

  logic [2:0]      state;
  logic [IDXW:0]   ptr;
  logic [IDXW:0]   count;
  logic [31:0]     cycle;
  logic [IDXW-1:0] fail_idx;
  logic [31:0]     fail_act;
  logic [31:0]     fail_exp;
  logic [1:0]      fail_code;

  logic [IDXW:0]   start_cnt;
  logic [31:0]     cur_num;
  logic [31:0]     cur_ans;
  logic [31:0]     nxt_ans;
  logic            active;
  logic            hit;
  logic            mismatch;
  logic            skipped;
  logic [IDXW:0]   ptr_post;

  assign start_cnt = (NUM_ENTRIES > MAX_CNT) ? MAX_CNT : NUM_ENTRIES;
  assign active    = (ptr < count);
  assign hit       = active && (NUM_INST == cur_num) && (OUTPUT_PORT == cur_ans);
  assign mismatch  = active && (NUM_INST == cur_num) && (OUTPUT_PORT != cur_ans);
  assign skipped   = active && (NUM_INST > cur_num);
  assign ptr_post  = ptr + {{IDXW{1'b0}}, hit};

  // Look up the current checkpoint and the one after a possible match this cycle.
  always_comb begin
    cur_num = '0;
    cur_ans = '0;
    nxt_ans = '0;
    for (int i = 0; i < NUM_TEST; i++) begin
      if (ptr == (IDXW+1)'(i)) begin
        cur_num = tab_num[i];
        cur_ans = tab_ans[i];
      end
      if (ptr_post == (IDXW+1)'(i)) begin
        nxt_ans = tab_ans[i];
      end
    end
  end

  // Checkpoint table: writable only while idle, cleared only by reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        tab_num[i] <= '0;
        tab_ans[i] <= '0;
      end
    end else if (state == ST_IDLE && LOAD_EN) begin
      for (int i = 0; i < NUM_TEST; i++) begin
        if (LOAD_IDX == IDXW'(i)) begin
          tab_num[i] <= LOAD_NUM_INST;
          tab_ans[i] <= LOAD_ANS;
        end
      end
    end
  end

  // Run control: checkpoint matching, halt resolution, timeout and fault capture.
  // The cycle counter only advances on cycles that stay in RUN, so a run that
  // times out reports TIMEOUT_CYCLES-1.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      count     <= '0;
      cycle     <= '0;
      fail_idx  <= '0;
      fail_act  <= '0;
      fail_exp  <= '0;
      fail_code <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            count <= start_cnt;
            ptr   <= '0;
            cycle <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            state     <= ST_FAIL;
            fail_code <= 2'd1;
            fail_idx  <= ptr[IDXW-1:0];
            fail_act  <= OUTPUT_PORT;
            fail_exp  <= cur_ans;
          end else if (skipped) begin
            state     <= ST_FAIL;
            fail_code <= 2'd2;
            fail_idx  <= ptr[IDXW-1:0];
            fail_act  <= OUTPUT_PORT;
            fail_exp  <= cur_ans;
          end else begin
            ptr <= ptr_post;
            if (HALT) begin
              if (ptr_post == count) begin
                state <= ST_PASS;
              end else begin
                state     <= ST_FAIL;
                fail_code <= 2'd3;
                fail_idx  <= ptr_post[IDXW-1:0];
                fail_act  <= OUTPUT_PORT;
                fail_exp  <= nxt_ans;
              end
            end else if (cycle == TIMEOUT_CYCLES - 32'd1) begin
              state <= ST_TIMEOUT;
            end else if (cycle != '1) begin
              cycle <= cycle + 32'd1;
            end
          end
        end
        ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          if (CLR) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            count     <= '0;
            cycle     <= '0;
            fail_idx  <= '0;
            fail_act  <= '0;
            fail_exp  <= '0;
            fail_code <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign STATE     = state;
  assign DONE      = (state == ST_PASS) || (state == ST_FAIL) || (state == ST_TIMEOUT);
  assign PASSED    = (state == ST_PASS);
  assign PASS_CNT  = ptr;
  assign CYCLE_CNT = cycle;
  assign FAIL_IDX  = fail_idx;
  assign FAIL_ACT  = fail_act;
  assign FAIL_EXP  = fail_exp;
  assign FAIL_CODE = fail_code;

endmodule

// File: tb/tb_rv_retire_checker.sv
// Testbench for rv_retire_checker: directed test-plan runs plus randomized
// runs, all compared against a checkpoint-walking reference model.
module tb_rv_retire_checker;

  localparam int NT    = 23;
  localparam int IW    = 5;
  localparam int TMO   = 50;
  localparam int NCYC  = 60;

  logic          CLK;
  logic          RSTn;
  logic          LOAD_EN;
  logic [IW-1:0] LOAD_IDX;
  logic [31:0]   LOAD_NUM_INST;
  logic [31:0]   LOAD_ANS;
  logic [IW:0]   NUM_ENTRIES;
  logic          START;
  logic          CLR;
  logic [31:0]   NUM_INST;
  logic [31:0]   OUTPUT_PORT;
  logic          HALT;
  logic [2:0]    STATE;
  logic          DONE;
  logic          PASSED;
  logic [IW:0]   PASS_CNT;
  logic [31:0]   CYCLE_CNT;
  logic [IW-1:0] FAIL_IDX;
  logic [31:0]   FAIL_ACT;
  logic [31:0]   FAIL_EXP;
  logic [1:0]    FAIL_CODE;

  rv_retire_checker #(.NUM_TEST(NT), .IDXW(IW), .TIMEOUT_CYCLES(32'd50)) dut (
    .CLK(CLK), .RSTn(RSTn), .LOAD_EN(LOAD_EN), .LOAD_IDX(LOAD_IDX),
    .LOAD_NUM_INST(LOAD_NUM_INST), .LOAD_ANS(LOAD_ANS), .NUM_ENTRIES(NUM_ENTRIES),
    .START(START), .CLR(CLR), .NUM_INST(NUM_INST), .OUTPUT_PORT(OUTPUT_PORT),
    .HALT(HALT), .STATE(STATE), .DONE(DONE), .PASSED(PASSED), .PASS_CNT(PASS_CNT),
    .CYCLE_CNT(CYCLE_CNT), .FAIL_IDX(FAIL_IDX), .FAIL_ACT(FAIL_ACT),
    .FAIL_EXP(FAIL_EXP), .FAIL_CODE(FAIL_CODE)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] tabNum [NT];
  logic [31:0] tabAns [NT];
  logic [31:0] sn [NCYC];
  logic [31:0] so [NCYC];
  bit          sh [NCYC];

  // Model results of the last run
  int          mState;
  int          mPtr;
  int          mCyc;
  int          mCode;
  int          mIdx;
  logic [31:0] mAct;
  logic [31:0] mExp;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic loadTable();
    for (int i = 0; i < NT; i++) begin
      LOAD_EN = 1'b1; LOAD_IDX = IW'(i);
      LOAD_NUM_INST = tabNum[i]; LOAD_ANS = tabAns[i];
      tick();
    end
    for (int i = NT; i < 32; i++) begin
      LOAD_EN = 1'b1; LOAD_IDX = IW'(i);
      LOAD_NUM_INST = $urandom; LOAD_ANS = $urandom;
      tick();
    end
    LOAD_EN = 1'b0;
  endtask

  task automatic directedTable();
    for (int i = 0; i < NT; i++) begin
      tabNum[i] = 32'(i + 1);
      if (i < 2)        tabAns[i] = 32'd0;
      else if (i == 2)  tabAns[i] = 32'd5;
      else if (i == 22) tabAns[i] = 32'h14;
      else              tabAns[i] = 32'(i * 3 + 1);
    end
  endtask

  // Fill all cycles with NUM_INST=v, answer 0, no halt
  task automatic fillStim(input logic [31:0] v);
    for (int c = 0; c < NCYC; c++) begin
      sn[c] = v; so[c] = 32'd0; sh[c] = 1'b0;
    end
  endtask

  // Retire entries 0..n-1 in order on cycles 0..n-1, then hold the last count
  task automatic walkStim(input int n);
    fillStim(n > 0 ? tabNum[n-1] : 32'd0);
    for (int c = 0; c < n; c++) begin
      sn[c] = tabNum[c]; so[c] = tabAns[c];
    end
    for (int c = n; c < NCYC; c++) so[c] = (n > 0) ? tabAns[n-1] : 32'd0;
  endtask

  // One RUN cycle of the reference model, straight from the checkpoint rules
  task automatic modelCycle(input int cnt, input logic [31:0] n, input logic [31:0] o, input bit h);
    bit act;
    if (mState != 1) return;
    act = (mPtr < cnt);
    if (act && n == tabNum[mPtr] && o != tabAns[mPtr]) begin
      mState = 3; mCode = 1; mIdx = mPtr; mAct = o; mExp = tabAns[mPtr];
    end else if (act && n > tabNum[mPtr]) begin
      mState = 3; mCode = 2; mIdx = mPtr; mAct = o; mExp = tabAns[mPtr];
    end else begin
      if (act && n == tabNum[mPtr]) mPtr++;
      if (h) begin
        if (mPtr == cnt) mState = 2;
        else begin
          mState = 3; mCode = 3; mIdx = mPtr; mAct = o; mExp = tabAns[mPtr];
        end
      end else if (mCyc == TMO - 1) begin
        mState = 4;
      end else begin
        mCyc++;
      end
    end
  endtask

  // START a run, drive the stimulus arrays with junk LOAD/START traffic, compare every cycle
  task automatic applyStimulus(input string name, input int numEntries);
    int cnt;
    cnt = (numEntries > NT) ? NT : numEntries;
    mState = 1; mPtr = 0; mCyc = 0; mCode = 0; mIdx = 0; mAct = 0; mExp = 0;
    NUM_ENTRIES = (IW+1)'(numEntries);
    START = 1'b1;
    tick();
    START = 1'b0;
    checkOutput({name, "_start_state"}, {29'd0, STATE}, 32'd1);
    checkOutput({name, "_start_cyc"}, CYCLE_CNT, 32'd0);
    for (int c = 0; c < NCYC; c++) begin
      NUM_INST = sn[c]; OUTPUT_PORT = so[c]; HALT = sh[c];
      LOAD_EN = 1'($urandom); LOAD_IDX = IW'($urandom_range(0, NT-1));
      LOAD_NUM_INST = $urandom; LOAD_ANS = $urandom;
      START = 1'($urandom);
      modelCycle(cnt, sn[c], so[c], sh[c]);
      tick();
      checkOutput($sformatf("%s_state_c%0d", name, c), {29'd0, STATE}, 32'(mState));
      checkOutput($sformatf("%s_pcnt_c%0d", name, c), {26'd0, PASS_CNT}, 32'(mPtr));
    end
    LOAD_EN = 1'b0; START = 1'b0; HALT = 1'b0;
    checkOutput({name, "_done"}, {31'd0, DONE}, 32'(mState >= 2));
    checkOutput({name, "_passed"}, {31'd0, PASSED}, 32'(mState == 2));
    checkOutput({name, "_cycle"}, CYCLE_CNT, 32'(mCyc));
    checkOutput({name, "_code"}, {30'd0, FAIL_CODE}, 32'(mCode));
    checkOutput({name, "_fidx"}, {27'd0, FAIL_IDX}, 32'(mIdx));
    checkOutput({name, "_fact"}, FAIL_ACT, mAct);
    checkOutput({name, "_fexp"}, FAIL_EXP, mExp);
  endtask

  task automatic clearRun(input string name);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    checkOutput({name, "_clr_state"}, {29'd0, STATE}, 32'd0);
    checkOutput({name, "_clr_pcnt"}, {26'd0, PASS_CNT}, 32'd0);
    checkOutput({name, "_clr_code"}, {30'd0, FAIL_CODE}, 32'd0);
    checkOutput({name, "_clr_cyc"}, CYCLE_CNT, 32'd0);
  endtask

  task automatic randomStim(input int cnt);
    int idx;
    int r;
    int haltAt;
    logic [31:0] last;
    idx = 0; last = 32'd0;
    haltAt = $urandom_range(0, NCYC);
    for (int c = 0; c < NCYC; c++) begin
      r = $urandom_range(0, 99);
      if (idx < cnt && r < 75) begin
        sn[c] = tabNum[idx]; so[c] = tabAns[idx]; idx++;
      end else if (idx < cnt && r < 80) begin
        sn[c] = tabNum[idx]; so[c] = tabAns[idx] ^ 32'd1;
      end else if (idx < cnt && r < 84) begin
        sn[c] = tabNum[idx] + 32'd1; so[c] = $urandom;
      end else begin
        sn[c] = last; so[c] = $urandom_range(0, 15);
      end
      last = sn[c];
      sh[c] = (c == haltAt);
    end
  endtask

  initial begin
    RSTn = 1'b0; LOAD_EN = 1'b0; LOAD_IDX = '0; LOAD_NUM_INST = '0; LOAD_ANS = '0;
    NUM_ENTRIES = '0; START = 1'b0; CLR = 1'b0; NUM_INST = '0; OUTPUT_PORT = '0; HALT = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_state", {29'd0, STATE}, 32'd0);
    checkOutput("rst_done", {31'd0, DONE}, 32'd0);
    checkOutput("rst_pcnt", {26'd0, PASS_CNT}, 32'd0);
    checkOutput("rst_cyc", CYCLE_CNT, 32'd0);
    checkOutput("rst_fail", {FAIL_IDX, FAIL_CODE} ^ FAIL_ACT ^ FAIL_EXP, 32'd0);
    RSTn = 1'b1;
    tick();

    directedTable();
    loadTable();

    walkStim(23); sh[23] = 1'b1;
    applyStimulus("full_pass", 23);
    checkOutput("full_pass_pcnt", {26'd0, PASS_CNT}, 32'd23);
    checkOutput("full_pass_passed", {31'd0, PASSED}, 32'd1);
    clearRun("full_pass");

    walkStim(2); sn[2] = 32'd3; so[2] = 32'd4;
    applyStimulus("mismatch", 23);
    checkOutput("mismatch_code", {30'd0, FAIL_CODE}, 32'd1);
    checkOutput("mismatch_idx", {27'd0, FAIL_IDX}, 32'd2);
    checkOutput("mismatch_act", FAIL_ACT, 32'd4);
    checkOutput("mismatch_exp", FAIL_EXP, 32'd5);
    checkOutput("mismatch_pcnt", {26'd0, PASS_CNT}, 32'd2);
    clearRun("mismatch");

    walkStim(2); sn[2] = 32'd4;
    applyStimulus("skip", 23);
    checkOutput("skip_code", {30'd0, FAIL_CODE}, 32'd2);
    checkOutput("skip_idx", {27'd0, FAIL_IDX}, 32'd2);
    clearRun("skip");

    walkStim(23); sh[22] = 1'b1;
    applyStimulus("halt_same", 23);
    checkOutput("halt_same_state", {29'd0, STATE}, 32'd2);
    clearRun("halt_same");

    walkStim(10); sh[9] = 1'b1;
    applyStimulus("early_halt", 23);
    checkOutput("early_halt_code", {30'd0, FAIL_CODE}, 32'd3);
    checkOutput("early_halt_idx", {27'd0, FAIL_IDX}, 32'd10);
    checkOutput("early_halt_exp", FAIL_EXP, tabAns[10]);
    clearRun("early_halt");

    fillStim(32'd0);
    applyStimulus("timeout", 23);
    checkOutput("timeout_state", {29'd0, STATE}, 32'd4);
    checkOutput("timeout_cyc", CYCLE_CNT, 32'd49);
    clearRun("timeout");

    fillStim(32'd0); sh[3] = 1'b1;
    applyStimulus("zero_cnt", 0);
    checkOutput("zero_cnt_state", {29'd0, STATE}, 32'd2);
    clearRun("zero_cnt");

    walkStim(23); sh[25] = 1'b1;
    applyStimulus("clamp_cnt", 40);
    checkOutput("clamp_cnt_state", {29'd0, STATE}, 32'd2);
    clearRun("clamp_cnt");

    walkStim(23); sh[24] = 1'b1;
    applyStimulus("restart_pass", 23);
    checkOutput("restart_pass_state", {29'd0, STATE}, 32'd2);
    clearRun("restart_pass");

    // Reset mid-run: outputs drop immediately, table is wiped
    NUM_ENTRIES = 6'd23; START = 1'b1; tick(); START = 1'b0;
    for (int c = 0; c < 5; c++) begin
      NUM_INST = tabNum[c]; OUTPUT_PORT = tabAns[c]; tick();
    end
    #2 RSTn = 1'b0;
    #1;
    checkOutput("midrst_state", {29'd0, STATE}, 32'd0);
    checkOutput("midrst_pcnt", {26'd0, PASS_CNT}, 32'd0);
    checkOutput("midrst_cyc", CYCLE_CNT, 32'd0);
    tick();
    RSTn = 1'b1;
    tick();
    for (int i = 0; i < NT; i++) begin
      tabNum[i] = 32'd0; tabAns[i] = 32'd0;
    end
    fillStim(32'd0); sh[2] = 1'b1;
    applyStimulus("after_rst", 2);
    checkOutput("after_rst_pcnt", {26'd0, PASS_CNT}, 32'd2);
    clearRun("after_rst");

    for (int k = 0; k < 20; k++) begin
      int cnt;
      logic [31:0] base;
      base = 32'($urandom_range(1, 5));
      for (int i = 0; i < NT; i++) begin
        tabNum[i] = base;
        tabAns[i] = 32'($urandom_range(0, 15));
        base = base + 32'($urandom_range(1, 4));
      end
      loadTable();
      cnt = $urandom_range(0, 30);
      randomStim(cnt > NT ? NT : cnt);
      applyStimulus($sformatf("rand%0d", k), cnt);
      clearRun($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
